rsa_engine_arbiter: RTL and testbench
=====================================

# rsa_engine_arbiter

Shares one modular-exponentiation engine (the `top_level_enc` core: start/done, message, key, modulus, result) between two requesters. Requester 0 is the host encrypt path and uses the public key. Requester 1 is the link-receive decrypt path and uses the private key. The block arbitrates round-robin, latches operands, sequences the engine's start/done handshake, range-checks messages and routes each result back with a tag. It sits between the computation master's request sources and a single engine instance, replacing the duplicated encode/decode engines.

## Interface
- `WIDTH`, 128: operand/result width.
- `E_KEY`, 17: exponent applied to requester 0.
- `D_KEY`, 157: exponent applied to requester 1.
- `N_MOD`, 2773: modulus for both requesters.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit; used only when the watchdog macro is defined.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 2: per-requester request valid.
- `req_data0`, `req_data1` in WIDTH: messages.
- `req_ready` out 2: per-requester accept.
- `res_valid` out 2: one-cycle result strobe per requester.
- `res_data` out WIDTH: result, shared by both requesters.
- `res_err` out 1: error qualifier, valid with `res_valid`.
- `busy` out 1: high from accept until result delivery.
- `eng_start` out 1: one-cycle engine start.
- `eng_message`, `eng_key`, `eng_n` out WIDTH: engine operands, held stable from start until done.
- `eng_c` in WIDTH: engine result.
- `eng_done` in 1: engine completion, high for at least 1 cycle.

## Operation
- States: IDLE, START, BUSY, DELIVER.
- **IDLE**
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not served last. Priority after reset: requester 0.
  - `req_ready` is high, combinationally, only for the granted requester, and only in IDLE with `reset` low.
  - On `req_valid[g] && req_ready[g]`:
    - latch the message into `eng_message`;
    - load `eng_key` with E_KEY or D_KEY;
    - latch the tag `g`.
  - Normal accept: go to START.
  - If the message >= N_MOD: go directly to DELIVER with the error set. The engine is not started.
- **START**: `eng_start`=1 for exactly this cycle, then BUSY. `eng_done` is ignored in START.
- **BUSY**: the first cycle `eng_done`=1 registers `eng_c` into `res_data` and moves to DELIVER. Later done cycles are ignored.
- **DELIVER**
  - `res_valid[tag]`=1 for one cycle. `res_data` and `res_err` are valid alongside it.
  - Update the round-robin pointer to the opposite of `tag`, then return to IDLE.
- `res_data` holds its last value until the next DELIVER.
- On an error, `res_data`=0 and `res_err`=1.
- `eng_n` is constant N_MOD.
- `busy` = state != IDLE.

## Timing
- Reset values: state IDLE, pointer 0. All outputs 0: `req_ready`, `res_valid`, `res_data`, `res_err`, `busy`, `eng_start`, `eng_message`, `eng_key`. Exception: `eng_n`=N_MOD.
- Accept at cycle T:
  - `eng_start` at T+1;
  - engine done at cycle D means `res_valid` at D+1;
  - the next `req_ready` is possible at D+2.
- Range-error accept at T: `res_valid` with `res_err` at T+1.
- Throughput: one operation in flight. A requester holding `req_valid` waits with no timeout, and its data must stay stable until accepted.
- A request arriving during DELIVER is not accepted until IDLE.
- Reset asserted mid-operation: everything returns to reset values immediately and any in-flight result is discarded. The engine shares `reset`, so it is cleared as well.

## Configuration
- `RSA_ARB_TIMEOUT_EN` defined:
  - a 32-bit counter runs in BUSY;
  - if it reaches TIMEOUT_CYCLES without `eng_done`, go to DELIVER with `res_err`=1 and `res_data`=0;
  - the counter clears on entering START.
- Not defined: no counter; BUSY waits indefinitely. The TIMEOUT_CYCLES parameter is accepted but unused.

## Structure
- Shared package `rsa_pkg`: state enum, tag constants (TAG_ENC=0, TAG_DEC=1), default key/modulus constants.
- Sub-module `rr_arbiter2`:
  - inputs: 2-bit request vector, last-served pointer;
  - output: one-hot grant;
  - purely combinational.
- FSM, operand latches and watchdog stay in `rsa_engine_arbiter`.

## Test plan
The bench uses a behavioural engine with 20-cycle latency, computing message^key mod n.
- Encrypt: `req_data0`=2 → one `eng_start` with key 17; `res_valid[0]`, `res_data`=741, `res_err`=0. Accept-to-result latency is 22 cycles.
- Decrypt: `req_data1`=741 → key 157; `res_valid[1]`, `res_data`=2.
- Contention: both valid from reset → served in order 0, 1, 0, 1. Each `req_ready` is one-hot and never asserted while `busy`.
- Range error: `req_data0`=2773 → no `eng_start`; `res_valid[0]` with `res_err`=1 and `res_data`=0, one cycle after accept.
- Reset mid-BUSY: assert `reset` 5 cycles after `eng_start` → all outputs 0 asynchronously and no `res_valid`. A new request after release completes normally.
- With `RSA_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=50, engine never done → `res_err`=1 exactly 50 cycles into BUSY, then IDLE.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA engine arbiter.
// Holds the FSM state encoding, requester tags and key/modulus defaults.
package rsa_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DELIVER
  } state_t;

  localparam logic TAG_ENC = 1'b0;
  localparam logic TAG_DEC = 1'b1;

  localparam int unsigned DEF_E_KEY   = 17;
  localparam int unsigned DEF_D_KEY   = 157;
  localparam int unsigned DEF_N_MOD   = 2773;
  localparam int unsigned DEF_TIMEOUT = 1000000;

  function automatic logic [1:0] tag_onehot(
    input logic t
  );
    return t ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; ptr names the requester favoured
// when both ask at once.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rsa_engine_arbiter.sv
// Shares one modexp engine between encrypt (0) and decrypt (1) paths.
// Optional BUSY watchdog enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_engine_arbiter
  import rsa_pkg::*;
#(
  parameter int unsigned      WIDTH          = 128,
  parameter logic [WIDTH-1:0] E_KEY          = WIDTH'(DEF_E_KEY),
  parameter logic [WIDTH-1:0] D_KEY          = WIDTH'(DEF_D_KEY),
  parameter logic [WIDTH-1:0] N_MOD          = WIDTH'(DEF_N_MOD),
  parameter int unsigned      TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic [1:0]       res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_message,
  output logic [WIDTH-1:0] eng_key,
  output logic [WIDTH-1:0] eng_n,
  input  logic [WIDTH-1:0] eng_c,
  input  logic             eng_done
);

  state_t           state;
  logic             prio;
  logic             tag;
  logic [1:0]       gnt;
  logic             g;
  logic             accept;
  logic [WIDTH-1:0] msg;
  logic             range_err;
  logic             timeout;

  rr_arbiter2 u_arb (
    .req (req_valid),
    .ptr (prio),
    .gnt (gnt)
  );

  assign req_ready = (state == S_IDLE && !reset) ? gnt : 2'b00;
  assign g         = gnt[1];
  assign accept    = |(req_valid & req_ready);
  assign msg       = (g == TAG_ENC) ? req_data0 : req_data1;
  assign range_err = msg >= N_MOD;
  assign eng_n     = N_MOD;
  assign busy      = state != S_IDLE;

`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0] wdog_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (state == S_IDLE && accept) begin
      wdog_cnt <= '0;
    end else if (state == S_BUSY) begin
      wdog_cnt <= wdog_cnt + 32'd1;
    end
  end

  // fires on the TIMEOUT_CYCLES-th BUSY cycle without done
  assign timeout = (state == S_BUSY) &&
                   (wdog_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      prio        <= 1'b0;
      tag         <= 1'b0;
      res_valid   <= 2'b00;
      res_data    <= '0;
      res_err     <= 1'b0;
      eng_start   <= 1'b0;
      eng_message <= '0;
      eng_key     <= '0;
    end else begin
      eng_start <= 1'b0;
      res_valid <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            eng_message <= msg;
            eng_key     <= (g == TAG_DEC) ? D_KEY : E_KEY;
            tag         <= g;
            if (range_err) begin
              state     <= S_DELIVER;
              res_valid <= tag_onehot(g);
              res_data  <= '0;
              res_err   <= 1'b1;
            end else begin
              state     <= S_START;
              eng_start <= 1'b1;
            end
          end
        end
        S_START: state <= S_BUSY;
        S_BUSY: begin
          if (eng_done) begin
            state     <= S_DELIVER;
            res_valid <= tag_onehot(tag);
            res_data  <= eng_c;
            res_err   <= 1'b0;
          end else if (timeout) begin
            state     <= S_DELIVER;
            res_valid <= tag_onehot(tag);
            res_data  <= '0;
            res_err   <= 1'b1;
          end
        end
        S_DELIVER: begin
          prio  <= ~tag;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Directed bench for rsa_engine_arbiter with a 20-cycle modexp model.
// Timeout step runs only when RSA_ARB_TIMEOUT_EN is defined.
module tb_rsa_engine_arbiter;

  localparam int W = 128;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [W-1:0] req_data0 = '0;
  logic [W-1:0] req_data1 = '0;
  logic [1:0]   req_ready;
  logic [1:0]   res_valid;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         busy;
  logic         eng_start;
  logic [W-1:0] eng_message;
  logic [W-1:0] eng_key;
  logic [W-1:0] eng_n;
  logic [W-1:0] eng_c;
  logic         eng_done;

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int n_start = 0;
  int start_cyc = 0;
  logic [W-1:0] start_key = '0;
  bit eng_hang = 1'b0;

  rsa_engine_arbiter #(
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data0   (req_data0),
    .req_data1   (req_data1),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy),
    .eng_start   (eng_start),
    .eng_message (eng_message),
    .eng_key     (eng_key),
    .eng_n       (eng_n),
    .eng_c       (eng_c),
    .eng_done    (eng_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic longint modexp(longint b, longint e, longint m);
    longint r = 1;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  int           e_cnt;
  logic [W-1:0] e_res;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      e_cnt    <= 0;
      e_res    <= '0;
      eng_done <= 1'b0;
      eng_c    <= '0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start && !eng_hang) begin
        e_cnt <= 19;
        e_res <= W'(modexp(longint'(eng_message),
                           longint'(eng_key),
                           longint'(eng_n)));
      end else if (e_cnt != 0) begin
        e_cnt <= e_cnt - 1;
        if (e_cnt == 1) begin
          eng_done <= 1'b1;
          eng_c    <= e_res;
        end
      end
    end
  end

  task automatic check(string tag, logic [W-1:0] obs,
                       logic [W-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (eng_start) begin
      n_start++;
      start_cyc = cyc;
      start_key = eng_key;
    end
    if (!reset) begin
      check("ready_onehot", W'($onehot0(req_ready)), 1);
      if (busy) check("ready_while_busy", W'(req_ready), 0);
    end
  end

  task automatic do_req(
    input  logic [1:0]   v,
    input  logic [W-1:0] m0,
    input  logic [W-1:0] m1,
    input  bit           drop,
    output logic [1:0]   gnt,
    output int           acc,
    output int           lat,
    output logic [1:0]   rv,
    output logic [W-1:0] rd,
    output logic         re
  );
    bit got;
    gnt = 2'b00; acc = 0; lat = -1;
    rv = 2'b00; rd = '0; re = 1'b0;
    @(negedge clock);
    req_valid = v; req_data0 = m0; req_data1 = m1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        got = 1'b1; gnt = req_ready; acc = cyc;
      end else begin
        @(negedge clock);
      end
    end
    check("accept_seen", W'(got), 1);
    if (!got) return;
    @(posedge clock);
    #1;
    if (drop) req_valid = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (res_valid != 2'b00) begin
        got = 1'b1; rv = res_valid; rd = res_data;
        re = res_err; lat = cyc - acc;
      end
    end
    check("result_seen", W'(got), 1);
  endtask

  logic [1:0]   gnt, rv;
  logic [W-1:0] rd;
  logic         re;
  int           acc, lat, ns0, seen;

  initial begin
    // reset values
    repeat (3) @(negedge clock);
    check("rst_req_ready", W'(req_ready), 0);
    check("rst_res_valid", W'(res_valid), 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", W'(res_err), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_eng_start", W'(eng_start), 0);
    check("rst_eng_message", eng_message, 0);
    check("rst_eng_key", eng_key, 0);
    check("rst_eng_n", eng_n, 2773);
    reset = 1'b0;

    // encrypt 2^17 mod 2773 = 741
    ns0 = n_start;
    do_req(2'b01, 2, 0, 1'b1, gnt, acc, lat, rv, rd, re);
    check("enc_grant", W'(gnt), 2'b01);
    check("enc_starts", W'(n_start - ns0), 1);
    check("enc_start_cyc", W'(start_cyc - acc), 1);
    check("enc_key", start_key, 17);
    check("enc_valid", W'(rv), 2'b01);
    check("enc_data", rd, 741);
    check("enc_err", W'(re), 0);
    check("enc_latency", W'(lat), 22);
    @(negedge clock);
    check("enc_idle_busy", W'(busy), 0);

    // decrypt 741^157 mod 2773 = 2
    do_req(2'b10, 0, 741, 1'b1, gnt, acc, lat, rv, rd, re);
    check("dec_grant", W'(gnt), 2'b10);
    check("dec_key", start_key, 157);
    check("dec_valid", W'(rv), 2'b10);
    check("dec_data", rd, 2);
    check("dec_err", W'(re), 0);
    check("dec_latency", W'(lat), 22);

    // contention from reset: 0,1,0,1
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_req(2'b11, 2, 741, 1'b0, gnt, acc, lat, rv, rd, re);
      check("rr_grant", W'(gnt), (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_valid", W'(rv), (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_data", rd, (k % 2 == 0) ? 741 : 2);
    end
    req_valid = 2'b00;

    // range error: message == N_MOD
    ns0 = n_start;
    do_req(2'b01, 2773, 0, 1'b1, gnt, acc, lat, rv, rd, re);
    check("rng_valid", W'(rv), 2'b01);
    check("rng_err", W'(re), 1);
    check("rng_data", rd, 0);
    check("rng_latency", W'(lat), 1);
    check("rng_no_start", W'(n_start - ns0), 0);

    // reset five cycles after eng_start
    @(negedge clock);
    ns0 = n_start;
    req_valid = 2'b01; req_data0 = 2;
    seen = 0;
    for (int i = 0; i < 20 && n_start == ns0; i++) begin
      @(posedge clock);
      #1;
      req_valid = 2'b00;
    end
    check("mid_start_seen", W'(n_start - ns0), 1);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mid_req_ready", W'(req_ready), 0);
    check("mid_res_valid", W'(res_valid), 0);
    check("mid_busy", W'(busy), 0);
    check("mid_eng_start", W'(eng_start), 0);
    check("mid_eng_message", eng_message, 0);
    check("mid_eng_key", eng_key, 0);
    check("mid_res_err", W'(res_err), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (res_valid != 2'b00) seen++;
    end
    check("mid_no_result", W'(seen), 0);
    do_req(2'b10, 0, 741, 1'b1, gnt, acc, lat, rv, rd, re);
    check("post_grant", W'(gnt), 2'b10);
    check("post_valid", W'(rv), 2'b10);
    check("post_data", rd, 2);
    check("post_latency", W'(lat), 22);

`ifdef RSA_ARB_TIMEOUT_EN
    // engine never finishes: watchdog after 50 BUSY cycles
    eng_hang = 1'b1;
    do_req(2'b01, 2, 0, 1'b1, gnt, acc, lat, rv, rd, re);
    check("wd_valid", W'(rv), 2'b01);
    check("wd_err", W'(re), 1);
    check("wd_data", rd, 0);
    check("wd_latency", W'(lat), 52);
    @(negedge clock);
    check("wd_idle", W'(busy), 0);
    eng_hang = 1'b0;
`endif

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
